bus_xfer_ctrl: RTL and testbench
================================

# bus_xfer_ctrl

Sequencer and arbiter for the shared 32-bit register bus. Up to NREQ requesters submit register-to-register transfers as (source, destination) pairs. The block grants one request at a time in round-robin order. For each transfer it drives the one-hot register-out selects (the R0out..R15out enables of the bus mux), then the one-hot register-in enables, so exactly one source drives the bus per transfer. It sits between the control unit / microsequencers and the bus mux plus register file.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- NREG, 16, number of bus sources/registers; index width fixed at 4

Ports:
- clock  in  1  rising-edge system clock
- clear  in  1  synchronous, active-high reset
- req_valid  in  NREQ  requester i has a pending transfer
- req_src  in  4*NREQ  source register index, slice [4i+3:4i]
- req_dst  in  4*NREQ  destination register index, slice [4i+3:4i]
- req_ready  out  NREQ  one-hot grant; transfer i accepted on the cycle where req_valid[i] and req_ready[i] are both high
- reg_out_sel  out  NREG  one-hot Rxout enables to the bus mux
- reg_in_en  out  NREG  one-hot Rxin enables to the register file
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after a transfer's LATCH cycle
- done_id  out  3  requester index of the completed transfer, valid with done

## Operation
- FSM states: IDLE, DRIVE, LATCH.
- IDLE:
  - The round-robin arbiter selects the lowest index at or above pointer `rr_ptr` (wrapping) with req_valid set.
  - req_ready is high for the winner only. This is combinational from state and req_valid.
  - On acceptance: register the winner's src, dst and id; set rr_ptr = (winner+1) mod NREQ; go to DRIVE.
  - With no valid request, stay in IDLE with all outputs 0.
- DRIVE: reg_out_sel = onehot(src); reg_in_en = 0 (bus settle cycle). Go to LATCH.
- LATCH: reg_out_sel = onehot(src); reg_in_en = onehot(dst). The destination captures the bus on the closing edge. Go to IDLE.
- done and done_id are registered and assert the cycle after LATCH.
- src == dst is performed normally as a harmless rewrite. No index filtering is needed because 4-bit indices always address 0..15.
- req_valid may drop before acceptance with no effect. Once a request is accepted, the captured src/dst are immune to later input changes.
- reg_out_sel and reg_in_en are never multi-hot. At most one bit of each is set in any cycle.

## Timing
- Reset values (clear high at an edge): state IDLE, rr_ptr 0, reg_out_sel 0, reg_in_en 0, done 0, done_id 0, busy 0. req_ready is 0 while clear is high.
- clear mid-transfer (DRIVE or LATCH): all outputs are 0 on the following cycle and the transfer is abandoned. If clear arrives in DRIVE, reg_in_en is never asserted.
- Latency from acceptance to the latching edge is 2 cycles. done follows one cycle after that.
- Throughput is 1 transfer per 3 cycles (default build).
- A requester that holds req_valid high after acceptance is treated as a new request in the next IDLE cycle.
- Simultaneous requests: rr_ptr guarantees that every continuously valid requester is granted within NREQ transfers.

## Configuration
- BUS_XFER_BACK2BACK_EN:
  - Defined: arbitration also runs during LATCH. req_ready may assert in LATCH, and on acceptance the FSM goes directly from LATCH to DRIVE, skipping IDLE. Throughput is 1 transfer per 2 cycles, and busy stays high across chained transfers.
  - Undefined: req_ready asserts only in IDLE, as described above.
- In both builds, clear overrides all behaviour.

## Structure
- Package bus_ctrl_pkg holds:
  - the state enum (IDLE, DRIVE, LATCH);
  - the REG_IDX_W = 4 constant;
  - NREG_DEF = 16;
  - a onehot-decode function shared with other bus users.
- One sub-module, rr_arbiter: NREQ request vector and pointer in; one-hot grant and encoded index out. It is purely combinational; rr_ptr lives in bus_xfer_ctrl.

## Test plan
- Single request: after clear, req_valid[0]=1, src=3, dst=7.
  - req_ready[0] high in the first IDLE cycle.
  - Next cycle: reg_out_sel=0x0008, reg_in_en=0.
  - Following cycle: reg_out_sel=0x0008, reg_in_en=0x0080.
  - Then done=1 with done_id=0.
- Round robin: all four requesters are held valid. The grant order is 0,1,2,3,0. reg_out_sel and reg_in_en are never multi-hot.
- Pointer wrap: rr_ptr=3 after a grant to 2; requesters 1 and 3 are valid. Requester 3 is granted first, then 1.
- clear in DRIVE: src=5, dst=9, clear pulsed during DRIVE. reg_in_en stays 0x0000 throughout, no done is produced, and the next grant starts from index 0.
- Self-transfer src=dst=15: reg_out_sel=0x8000 and reg_in_en=0x8000 together in LATCH, then done.
- Build with BUS_XFER_BACK2BACK_EN: two requesters valid. The second is accepted in the first transfer's LATCH cycle, and its DRIVE follows immediately, giving 4 cycles for two transfers.

Source files
------------

// File: rtl/bus_ctrl_pkg.sv
// Shared definitions for the register-bus transfer controller and other bus users.
package bus_ctrl_pkg;

  localparam int REG_IDX_W = 4;
  localparam int NREG_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    LATCH = 2'd2
  } state_e;

  function automatic logic [NREG_DEF-1:0] onehot_dec(input logic [REG_IDX_W-1:0] idx);
    logic [NREG_DEF-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/bus_xfer_ctrl_if.sv
// Requester handshake plus bus-mux / register-file enables of the transfer controller.
interface bus_xfer_ctrl_if #(
  parameter int NREQ = 4,
  parameter int NREG = 16
);
  logic [NREQ-1:0]   req_valid;
  logic [4*NREQ-1:0] req_src;
  logic [4*NREQ-1:0] req_dst;
  logic [NREQ-1:0]   req_ready;
  logic [NREG-1:0]   reg_out_sel;
  logic [NREG-1:0]   reg_in_en;
  logic              busy;
  logic              done;
  logic [2:0]        done_id;

  modport master (
    output req_valid, req_src, req_dst,
    input  req_ready, reg_out_sel, reg_in_en, busy, done, done_id
  );

  modport slave (
    input  req_valid, req_src, req_dst,
    output req_ready, reg_out_sel, reg_in_en, busy, done, done_id
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr_i, wrapping.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [2:0]      ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [2:0]      idx_o,
  output logic            any_o
);

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (int'(ptr_i) + k) % NREQ;
      if (!any_o && req_i[j]) begin
        any_o      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = 3'(j);
      end
    end
  end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Round-robin sequencer for register-to-register bus transfers (IDLE -> DRIVE -> LATCH).
// Optional macro BUS_XFER_BACK2BACK_EN lets arbitration also run in LATCH to chain transfers.
module bus_xfer_ctrl
  import bus_ctrl_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int NREG = NREG_DEF
) (
  input  logic          clock,
  input  logic          clear,
  bus_xfer_ctrl_if.slave bus
);

  state_e                 state_q;
  logic [2:0]             rr_ptr_q;
  logic [REG_IDX_W-1:0]   src_q;
  logic [REG_IDX_W-1:0]   dst_q;
  logic [2:0]             id_q;
  logic [NREG-1:0]        reg_out_sel_q;
  logic [NREG-1:0]        reg_in_en_q;
  logic                   busy_q;
  logic                   done_q;
  logic [2:0]             done_id_q;

  logic [NREQ-1:0]        arb_grant;
  logic [2:0]             arb_idx;
  logic                   arb_any;
  logic                   grant_window;
  logic                   accept;
  logic [REG_IDX_W-1:0]   win_src;
  logic [REG_IDX_W-1:0]   win_dst;
  logic [2:0]             rr_ptr_d;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i   (bus.req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .any_o   (arb_any)
  );

  always_comb begin
`ifdef BUS_XFER_BACK2BACK_EN
    grant_window = (state_q == IDLE) || (state_q == LATCH);
`else
    grant_window = (state_q == IDLE);
`endif
  end

  assign bus.req_ready = arb_grant & {NREQ{grant_window & ~clear}};
  assign accept        = arb_any & grant_window;
  assign rr_ptr_d      = (arb_idx == 3'(NREQ - 1)) ? 3'd0 : arb_idx + 3'd1;

  always_comb begin
    win_src = '0;
    win_dst = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_idx == 3'(i)) begin
        win_src = bus.req_src[4*i +: 4];
        win_dst = bus.req_dst[4*i +: 4];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      src_q         <= '0;
      dst_q         <= '0;
      id_q          <= '0;
      reg_out_sel_q <= '0;
      reg_in_en_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      done_id_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            src_q         <= win_src;
            dst_q         <= win_dst;
            id_q          <= arb_idx;
            rr_ptr_q      <= rr_ptr_d;
            reg_out_sel_q <= NREG'(onehot_dec(win_src));
            reg_in_en_q   <= '0;
            busy_q        <= 1'b1;
            state_q       <= DRIVE;
          end
        end
        DRIVE: begin
          // Source keeps driving; destination enable opens only after the settle cycle.
          reg_in_en_q <= NREG'(onehot_dec(dst_q));
          state_q     <= LATCH;
        end
        LATCH: begin
          done_q    <= 1'b1;
          done_id_q <= id_q;
          if (accept) begin
            src_q         <= win_src;
            dst_q         <= win_dst;
            id_q          <= arb_idx;
            rr_ptr_q      <= rr_ptr_d;
            reg_out_sel_q <= NREG'(onehot_dec(win_src));
            reg_in_en_q   <= '0;
            state_q       <= DRIVE;
          end else begin
            reg_out_sel_q <= '0;
            reg_in_en_q   <= '0;
            busy_q        <= 1'b0;
            state_q       <= IDLE;
          end
        end
        default: begin
          reg_out_sel_q <= '0;
          reg_in_en_q   <= '0;
          busy_q        <= 1'b0;
          state_q       <= IDLE;
        end
      endcase
    end
  end

  assign bus.reg_out_sel = reg_out_sel_q;
  assign bus.reg_in_en   = reg_in_en_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.done_id     = done_id_q;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Directed self-checking bench for bus_xfer_ctrl (NREQ=4, NREG=16).
module tb_bus_xfer_ctrl;

  logic clk = 1'b0;
  logic clear;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bus_xfer_ctrl_if #(.NREQ(4), .NREG(16)) bus ();

  bus_xfer_ctrl #(.NREQ(4), .NREG(16)) dut (
    .clock (clk),
    .clear (clear),
    .bus   (bus)
  );

  always @(negedge clk) begin
    if (bus.done === 1'b1) $display("xfer done id=%0d", bus.done_id);
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic set_req(input int i, input logic [3:0] s, input logic [3:0] d);
    bus.req_src[4*i +: 4] = s;
    bus.req_dst[4*i +: 4] = d;
  endtask

  task automatic do_clear();
    clear         = 1'b1;
    bus.req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    clear         = 1'b1;
    bus.req_valid = 4'hF;
    bus.req_src   = 16'h4321;
    bus.req_dst   = 16'h8765;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ready got %b want 0000", bus.req_ready);
    end
    checks++;
    if ({bus.reg_out_sel, bus.reg_in_en, bus.busy, bus.done, bus.done_id} !== 37'd0) begin
      errors++;
      $display("FAIL reset_outputs sel=%h en=%h busy=%b done=%b id=%0d want all 0",
               bus.reg_out_sel, bus.reg_in_en, bus.busy, bus.done, bus.done_id);
    end
    bus.req_valid = '0;
    clear         = 1'b0;
  endtask

  task automatic test_single();
    do_clear();
    set_req(0, 4'd3, 4'd7);
    bus.req_valid = 4'b0001;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL single_ready got %b want 0001", bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = '0;
    checks++;
    if ({bus.reg_out_sel, bus.reg_in_en, bus.busy} !== {16'h0008, 16'h0000, 1'b1}) begin
      errors++;
      $display("FAIL single_drive sel=%h en=%h busy=%b want 0008 0000 1",
               bus.reg_out_sel, bus.reg_in_en, bus.busy);
    end
    @(negedge clk);
    checks++;
    if ({bus.reg_out_sel, bus.reg_in_en} !== {16'h0008, 16'h0080}) begin
      errors++;
      $display("FAIL single_latch sel=%h en=%h want 0008 0080", bus.reg_out_sel, bus.reg_in_en);
    end
    @(negedge clk);
    checks++;
    if ({bus.done, bus.done_id, bus.busy, bus.reg_out_sel, bus.reg_in_en} !== {1'b1, 3'd0, 1'b0, 32'd0}) begin
      errors++;
      $display("FAIL single_done done=%b id=%0d busy=%b sel=%h en=%h want 1 0 0 0000 0000",
               bus.done, bus.done_id, bus.busy, bus.reg_out_sel, bus.reg_in_en);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL single_done_pulse done=%b want 0", bus.done);
    end
  endtask

  task automatic test_round_robin();
    int exp_order [5] = '{0, 1, 2, 3, 0};
    do_clear();
    for (int i = 0; i < 4; i++) set_req(i, 4'(i + 1), 4'(i + 8));
    bus.req_valid = 4'hF;
    #1;
    for (int t = 0; t < 5; t++) begin
      int w = 0;
      while (bus.req_ready === 4'b0000 && w < 8) begin
        @(negedge clk);
        #1;
        w++;
      end
      checks++;
      if (bus.req_ready !== 4'(1 << exp_order[t])) begin
        errors++;
        $display("FAIL rr_grant[%0d] got %b want %b", t, bus.req_ready, 4'(1 << exp_order[t]));
      end
      if (t > 0) begin
        checks++;
        if ({bus.done, bus.done_id} !== {1'b1, 3'(exp_order[t-1])}) begin
          errors++;
          $display("FAIL rr_done[%0d] done=%b id=%0d want 1 %0d", t, bus.done, bus.done_id, exp_order[t-1]);
        end
      end
      for (int c = 0; c < 2; c++) begin
        @(negedge clk);
        if (t == 4) bus.req_valid = '0;
        checks++;
        if ($countones(bus.reg_out_sel) > 1 || $countones(bus.reg_in_en) > 1 ||
            bus.reg_out_sel !== 16'(1 << (exp_order[t] + 1))) begin
          errors++;
          $display("FAIL rr_onehot[%0d.%0d] sel=%h en=%h want sel %h", t, c,
                   bus.reg_out_sel, bus.reg_in_en, 16'(1 << (exp_order[t] + 1)));
        end
      end
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_ptr_wrap();
    do_clear();
    for (int i = 0; i < 4; i++) set_req(i, 4'(i), 4'(15 - i));
    bus.req_valid = 4'b0100;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL wrap_first got %b want 0100", bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    bus.req_valid = 4'b1010;
    #1;
    checks++;
    if (bus.req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL wrap_second got %b want 1000", bus.req_ready);
    end
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (bus.req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL wrap_third got %b want 0010", bus.req_ready);
    end
    bus.req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_clear_drive();
    do_clear();
    set_req(1, 4'd5, 4'd9);
    bus.req_valid = 4'b0010;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL clr_ready got %b want 0010", bus.req_ready);
    end
    @(negedge clk);
    checks++;
    if ({bus.reg_out_sel, bus.reg_in_en} !== {16'h0020, 16'h0000}) begin
      errors++;
      $display("FAIL clr_drive sel=%h en=%h want 0020 0000", bus.reg_out_sel, bus.reg_in_en);
    end
    clear         = 1'b1;
    bus.req_valid = 4'b0101;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL clr_ready_low got %b want 0000", bus.req_ready);
    end
    bus.req_valid = '0;
    @(negedge clk);
    checks++;
    if ({bus.reg_out_sel, bus.reg_in_en, bus.busy, bus.done} !== 34'd0) begin
      errors++;
      $display("FAIL clr_abandon sel=%h en=%h busy=%b done=%b want all 0",
               bus.reg_out_sel, bus.reg_in_en, bus.busy, bus.done);
    end
    clear = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if ({bus.reg_in_en, bus.done} !== 17'd0) begin
        errors++;
        $display("FAIL clr_quiet[%0d] en=%h done=%b want 0000 0", c, bus.reg_in_en, bus.done);
      end
    end
    bus.req_valid = 4'b0101;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL clr_ptr_reset got %b want 0001", bus.req_ready);
    end
    bus.req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_self();
    do_clear();
    set_req(0, 4'd15, 4'd15);
    bus.req_valid = 4'b0001;
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    checks++;
    if ({bus.reg_out_sel, bus.reg_in_en} !== {16'h8000, 16'h8000}) begin
      errors++;
      $display("FAIL self_latch sel=%h en=%h want 8000 8000", bus.reg_out_sel, bus.reg_in_en);
    end
    @(negedge clk);
    checks++;
    if ({bus.done, bus.done_id} !== {1'b1, 3'd0}) begin
      errors++;
      $display("FAIL self_done done=%b id=%0d want 1 0", bus.done, bus.done_id);
    end
  endtask

  task automatic test_back_to_back();
    do_clear();
    set_req(0, 4'd2, 4'd4);
    set_req(1, 4'd6, 4'd10);
    bus.req_valid = 4'b0011;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL b2b_first got %b want 0001", bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = 4'b0010;
    checks++;
    if ({bus.reg_out_sel, bus.reg_in_en} !== {16'h0004, 16'h0000}) begin
      errors++;
      $display("FAIL b2b_drive0 sel=%h en=%h want 0004 0000", bus.reg_out_sel, bus.reg_in_en);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({bus.reg_out_sel, bus.reg_in_en} !== {16'h0004, 16'h0010}) begin
      errors++;
      $display("FAIL b2b_latch0 sel=%h en=%h want 0004 0010", bus.reg_out_sel, bus.reg_in_en);
    end
`ifdef BUS_XFER_BACK2BACK_EN
    checks++;
    if (bus.req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL b2b_latch_ready got %b want 0010", bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = '0;
    checks++;
    if ({bus.reg_out_sel, bus.reg_in_en, bus.busy, bus.done, bus.done_id} !== {16'h0040, 16'h0000, 1'b1, 1'b1, 3'd0}) begin
      errors++;
      $display("FAIL b2b_drive1 sel=%h en=%h busy=%b done=%b id=%0d want 0040 0000 1 1 0",
               bus.reg_out_sel, bus.reg_in_en, bus.busy, bus.done, bus.done_id);
    end
`else
    checks++;
    if (bus.req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL b2b_latch_ready got %b want 0000", bus.req_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({bus.req_ready, bus.busy, bus.done, bus.done_id} !== {4'b0010, 1'b0, 1'b1, 3'd0}) begin
      errors++;
      $display("FAIL b2b_idle ready=%b busy=%b done=%b id=%0d want 0010 0 1 0",
               bus.req_ready, bus.busy, bus.done, bus.done_id);
    end
    @(negedge clk);
    bus.req_valid = '0;
    checks++;
    if ({bus.reg_out_sel, bus.reg_in_en} !== {16'h0040, 16'h0000}) begin
      errors++;
      $display("FAIL b2b_drive1 sel=%h en=%h want 0040 0000", bus.reg_out_sel, bus.reg_in_en);
    end
`endif
    @(negedge clk);
    checks++;
    if ({bus.reg_out_sel, bus.reg_in_en} !== {16'h0040, 16'h0400}) begin
      errors++;
      $display("FAIL b2b_latch1 sel=%h en=%h want 0040 0400", bus.reg_out_sel, bus.reg_in_en);
    end
    @(negedge clk);
    checks++;
    if ({bus.done, bus.done_id, bus.busy} !== {1'b1, 3'd1, 1'b0}) begin
      errors++;
      $display("FAIL b2b_done1 done=%b id=%0d busy=%b want 1 1 0", bus.done, bus.done_id, bus.busy);
    end
  endtask

  initial begin
    clear         = 1'b1;
    bus.req_valid = '0;
    bus.req_src   = '0;
    bus.req_dst   = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_ptr_wrap();
    test_clear_drive();
    test_self();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
